vp_wb_block_receiver: RTL and testbench

- Per-core slave end of the memory-controller block-copy bus.
- Accepts 32-bit beats strobed by the memory controller.
- Assembles them into 64-bit instruction words (2 beats) or 96-bit vector data words (3 beats).
- Writes each completed word into the core's code or data memory and acknowledges every beat with ACK_O.
- One instance sits in front of each VP core's instruction/data RAM write ports.

---
 rtl/vp_wb_block_receiver.sv | 176 +++++++++++++++++
 tb/tb_vp_wb_block_receiver.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vp_wb_block_receiver.sv
// Per-core slave of the memory-controller block-copy bus: assembles 32-bit beats into
// 64-bit code words (2 beats) or 96-bit data words (3 beats) and writes them to core memory.
//
// state  | meaning
// IDLE   | no word in progress; waiting for the first beat
// ACK    | acknowledging the beat just captured; decide next step
// WAIT   | word partially assembled; waiting for the next beat
// COMMIT | word complete; one-cycle write pulse to code or data memory
module vp_wb_block_receiver #(
    parameter int         CORE_ID    = 0,
    parameter int         CORE_COUNT = 4,
    parameter int         WB_WIDTH   = 32,
    parameter int         CODE_AW    = 16,
    parameter int         DATA_AW    = 16,
    parameter logic [1:0] TAG_CODE   = 2'd1,
    parameter logic [1:0] TAG_DATA   = 2'd2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  CYC_I,
    input  logic                  MST_I,
    input  logic                  STB_I,
    input  logic [CORE_COUNT-1:0] WE_I,
    input  logic [1:0]            TAG_I,
    input  logic [WB_WIDTH-1:0]   ADR_I,
    input  logic [WB_WIDTH-1:0]   DAT_I,
    output logic                  ACK_O,
    output logic                  oCodeWE,
    output logic [CODE_AW-1:0]    oCodeAddr,
    output logic [63:0]           oCodeData,
    output logic                  oDataWE,
    output logic [DATA_AW-1:0]    oDataAddr,
    output logic [95:0]           oDataData,
    output logic                  oBusy,
    output logic                  oProtocolError
);

    typedef enum logic [1:0] {IDLE, ACK, WAIT, COMMIT} stateT;

    stateT               state, nextState;
    logic                sel, newBeat, beatReq;
    logic                stbPrev, pending, pendingNext;
    logic [1:0]          beatCount, countNext, countInc, beatsNeeded;
    logic [1:0]          tagLatch;
    logic [WB_WIDTH-1:0] adrLatch;
    logic [31:0]         slot0, slot1, slot2;
    logic                isCode, isData, badTag;
    logic                capture, latchHdr, commitLoad, setErr;
    logic                protocolErr;
    logic                unusedSink;

    assign sel         = CYC_I & MST_I & WE_I[CORE_ID];
    assign newBeat     = STB_I & ~stbPrev & sel;
    assign beatReq     = newBeat | pending;
    assign isCode      = (tagLatch == TAG_CODE);
    assign isData      = (tagLatch == TAG_DATA);
    assign badTag      = ~isCode & ~isData;
    assign beatsNeeded = isData ? 2'd3 : 2'd2;
    assign countInc    = beatCount + 2'd1;
    assign unusedSink  = ^{adrLatch, WE_I, DAT_I};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            stbPrev   <= 1'b0;
            pending   <= 1'b0;
            beatCount <= 2'd0;
        end else begin
            state     <= nextState;
            stbPrev   <= STB_I;
            pending   <= pendingNext;
            beatCount <= countNext;
        end
    end

    // An edge seen while in ACK or COMMIT is held in 'pending' and serviced next IDLE/WAIT.
    always_comb begin
        nextState   = state;
        countNext   = beatCount;
        pendingNext = 1'b0;
        capture     = 1'b0;
        latchHdr    = 1'b0;
        commitLoad  = 1'b0;
        setErr      = 1'b0;
        case (state)
            IDLE: begin
                if (beatReq) begin
                    latchHdr  = 1'b1;
                    capture   = 1'b1;
                    nextState = ACK;
                end
            end
            ACK: begin
                pendingNext = pending | newBeat;
                if (badTag) begin
                    setErr    = 1'b1;
                    countNext = 2'd0;
                    nextState = IDLE;
                end else if (countInc == beatsNeeded) begin
                    countNext  = countInc;
                    commitLoad = 1'b1;
                    nextState  = COMMIT;
                end else if (!sel) begin
                    setErr      = 1'b1;
                    countNext   = 2'd0;
                    pendingNext = 1'b0;
                    nextState   = IDLE;
                end else begin
                    countNext = countInc;
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (!sel) begin
                    setErr    = 1'b1;
                    countNext = 2'd0;
                    nextState = IDLE;
                end else if (beatReq) begin
                    capture   = 1'b1;
                    nextState = ACK;
                end
            end
            COMMIT: begin
                pendingNext = pending | newBeat;
                countNext   = 2'd0;
                nextState   = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            tagLatch    <= 2'd0;
            adrLatch    <= '0;
            slot0       <= 32'd0;
            slot1       <= 32'd0;
            slot2       <= 32'd0;
            oCodeAddr   <= '0;
            oCodeData   <= 64'd0;
            oDataAddr   <= '0;
            oDataData   <= 96'd0;
            protocolErr <= 1'b0;
        end else begin
            if (latchHdr) begin
                tagLatch <= TAG_I;
                adrLatch <= ADR_I;
            end
            if (capture) begin
                case (beatCount)
                    2'd0:    slot0 <= DAT_I[31:0];
                    2'd1:    slot1 <= DAT_I[31:0];
                    default: slot2 <= DAT_I[31:0];
                endcase
            end
            // Beat 0 lands in the most significant slot of the word.
            if (commitLoad) begin
                if (isCode) begin
                    oCodeAddr <= adrLatch[CODE_AW-1:0];
                    oCodeData <= {slot0, slot1};
                end else begin
                    oDataAddr <= adrLatch[DATA_AW-1:0];
                    oDataData <= {slot0, slot1, slot2};
                end
            end
            if (setErr) protocolErr <= 1'b1;
        end
    end

    assign ACK_O          = (state == ACK);
    assign oBusy          = (state == WAIT);
    assign oCodeWE        = (state == COMMIT) & isCode;
    assign oDataWE        = (state == COMMIT) & isData;
    assign oProtocolError = protocolErr;

endmodule

// File: tb/tb_vp_wb_block_receiver.sv
// Bench for vp_wb_block_receiver: directed test-plan words plus randomized traffic,
// checked against a queue-based model of the expected memory writes and error flag.
module tb_vp_wb_block_receiver;

    localparam int CID = 1;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        CYC_I = 1'b0, MST_I = 1'b0, STB_I = 1'b0;
    logic [3:0]  WE_I  = 4'd0;
    logic [1:0]  TAG_I = 2'd0;
    logic [31:0] ADR_I = 32'd0, DAT_I = 32'd0;
    logic        ACK_O, oCodeWE, oDataWE, oBusy, oProtocolError;
    logic [15:0] oCodeAddr, oDataAddr;
    logic [63:0] oCodeData;
    logic [95:0] oDataData;

    vp_wb_block_receiver #(.CORE_ID(CID), .CORE_COUNT(4)) dut (
        .Clock(Clock), .Reset(Reset), .CYC_I(CYC_I), .MST_I(MST_I), .STB_I(STB_I),
        .WE_I(WE_I), .TAG_I(TAG_I), .ADR_I(ADR_I), .DAT_I(DAT_I), .ACK_O(ACK_O),
        .oCodeWE(oCodeWE), .oCodeAddr(oCodeAddr), .oCodeData(oCodeData),
        .oDataWE(oDataWE), .oDataAddr(oDataAddr), .oDataData(oDataData),
        .oBusy(oBusy), .oProtocolError(oProtocolError)
    );

    always #5 Clock = ~Clock;

    int           vectors = 0, miscompares = 0;
    int           codeWrites = 0, dataWrites = 0;
    logic         modelErr = 1'b0;
    bit           midWord = 1'b0, otherTraffic = 1'b0;
    logic [79:0]  codeQ[$];
    logic [111:0] dataQ[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model: every write pulse must match the next expected word.
    always @(negedge Clock) begin
        logic [79:0]  ec;
        logic [111:0] ed;
        if (Reset === 1'b1) begin
            if (oCodeWE) begin
                codeWrites++;
                if (codeQ.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected code write: addr %0h data %0h expected none", oCodeAddr, oCodeData);
                end else begin
                    ec = codeQ.pop_front();
                    check("code write addr", 128'(oCodeAddr), 128'(ec[79:64]));
                    check("code write data", 128'(oCodeData), 128'(ec[63:0]));
                end
            end
            if (oDataWE) begin
                dataWrites++;
                if (dataQ.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected data write: addr %0h data %0h expected none", oDataAddr, oDataData);
                end else begin
                    ed = dataQ.pop_front();
                    check("data write addr", 128'(oDataAddr), 128'(ed[111:96]));
                    check("data write data", 128'(oDataData), 128'(ed[95:0]));
                end
            end
            if (otherTraffic) check("ack while other core owns bus", 128'(ACK_O), 128'(0));
            if (!midWord) check("protocol error flag", 128'(oProtocolError), 128'(modelErr));
        end
    end

    task automatic doBeat(input logic [31:0] d, input bit dropCyc, output bit ok, output int lat,
                          output logic ackAfter, output logic busy, output logic cwe, output logic dwe);
        DAT_I = d;
        STB_I = 1'b1;
        ok    = 1'b0;
        lat   = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clock); #1;
            if (ACK_O) begin
                ok  = 1'b1;
                lat = i + 1;
                break;
            end
        end
        STB_I = 1'b0;
        if (dropCyc) CYC_I = 1'b0;
        @(posedge Clock); #1;
        ackAfter = ACK_O;
        busy     = oBusy;
        cwe      = oCodeWE;
        dwe      = oDataWE;
    endtask

    task automatic doWord(input logic [1:0] tag, input logic [31:0] adr, input logic [31:0] b0,
                          input logic [31:0] b1, input logic [31:0] b2, input int abortAfter,
                          input bit dropLate, input int gap, output int firstLat);
        logic [31:0] beats [3];
        int          n, sendN, lat;
        bit          complete, valid, lateDrop, last, ok;
        logic        ackAfter, busy, cwe, dwe;
        beats    = '{b0, b1, b2};
        valid    = (tag == 2'd1) || (tag == 2'd2);
        n        = (tag == 2'd2) ? 3 : (tag == 2'd1) ? 2 : 1;
        sendN    = (abortAfter > 0 && abortAfter < n) ? abortAfter : n;
        complete = valid && (sendN == n);
        lateDrop = valid && !complete && dropLate;
        firstLat = 0;
        midWord  = 1'b1;
        if (complete && tag == 2'd1) codeQ.push_back({adr[15:0], b0, b1});
        if (complete && tag == 2'd2) dataQ.push_back({adr[15:0], b0, b1, b2});
        CYC_I = 1'b1; MST_I = 1'b1; WE_I = 4'(1 << CID); TAG_I = tag; ADR_I = adr;
        for (int i = 0; i < sendN; i++) begin
            last = (i == sendN - 1);
            doBeat(beats[i], last && !lateDrop, ok, lat, ackAfter, busy, cwe, dwe);
            if (i == 0) firstLat = lat;
            check("beat acknowledged", 128'(ok), 128'(1));
            check("ack lasts one cycle", 128'(ackAfter), 128'(0));
            check("busy after beat", 128'(busy), 128'(!last || lateDrop));
            check("code we after final ack", 128'(cwe), 128'(last && complete && tag == 2'd1));
            check("data we after final ack", 128'(dwe), 128'(last && complete && tag == 2'd2));
        end
        if (lateDrop) begin
            CYC_I = 1'b0;
            @(posedge Clock); #1;
        end
        if (!complete) modelErr = 1'b1;
        CYC_I = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge Clock); #1;
        end
        midWord = 1'b0;
    endtask

    task automatic otherCore(input int beats, input bit mstLow);
        logic [3:0] w;
        w = 4'($urandom_range(0, 15));
        if (mstLow) w[CID] = 1'b1;
        else        w[CID] = 1'b0;
        otherTraffic = 1'b1;
        CYC_I = 1'b1; MST_I = !mstLow; WE_I = w; TAG_I = 2'($urandom); ADR_I = $urandom;
        for (int b = 0; b < beats; b++) begin
            DAT_I = $urandom;
            STB_I = 1'b1;
            @(posedge Clock); #1;
            @(posedge Clock); #1;
            STB_I = 1'b0;
            @(posedge Clock); #1;
        end
        check("busy after other-core traffic", 128'(oBusy), 128'(0));
        CYC_I = 1'b0; MST_I = 1'b0;
        @(posedge Clock); #1;
        otherTraffic = 1'b0;
    endtask

    initial begin
        int   lat, c0, d0, r;
        bit   ok;
        logic ackAfter, busy, cwe, dwe;
        logic [1:0] tag;

        repeat (2) @(posedge Clock);
        #1;
        check("reset ACK_O", 128'(ACK_O), 128'(0));
        check("reset oCodeWE", 128'(oCodeWE), 128'(0));
        check("reset oDataWE", 128'(oDataWE), 128'(0));
        check("reset oBusy", 128'(oBusy), 128'(0));
        check("reset oProtocolError", 128'(oProtocolError), 128'(0));
        check("reset oCodeData", 128'(oCodeData), 128'(0));
        check("reset oDataData", 128'(oDataData), 128'(0));
        Reset = 1'b1;
        @(posedge Clock); #1;

        doWord(2'd1, 32'h10, 32'hAAAA0001, 32'hBBBB0002, 32'h0, 0, 1'b0, 2, lat);
        check("first ack latency", 128'(lat), 128'(1));
        check("code word addr", 128'(oCodeAddr), 128'(16'h0010));
        check("code word data", 128'(oCodeData), 128'(64'hAAAA0001BBBB0002));
        check("no data write for code word", 128'(dataWrites), 128'(0));

        doWord(2'd2, 32'h5, 32'h1, 32'h2, 32'h3, 0, 1'b0, 2, lat);
        check("data word addr", 128'(oDataAddr), 128'(16'h0005));
        check("data word data", 128'(oDataData), 128'(96'h000000010000000200000003));
        check("code data held", 128'(oCodeData), 128'(64'hAAAA0001BBBB0002));

        otherCore(3, 1'b0);
        otherCore(2, 1'b1);

        d0 = dataWrites;
        doWord(2'd2, 32'h20, 32'h9, 32'h8, 32'h7, 2, 1'b0, 2, lat);
        check("error after abort", 128'(oProtocolError), 128'(1));
        check("no write after abort", 128'(dataWrites - d0), 128'(0));
        doWord(2'd1, 32'h30, 32'hCAFE0000, 32'h0000BEEF, 32'h0, 0, 1'b0, 2, lat);
        check("code word after abort", 128'(oCodeData), 128'(64'hCAFE00000000BEEF));

        c0 = codeWrites;
        for (int a = 0; a < 4; a++)
            doWord(2'd1, 32'(a), $urandom, $urandom, 32'h0, 0, 1'b0, 0, lat);
        repeat (2) @(posedge Clock);
        #1;
        check("back-to-back code writes", 128'(codeWrites - c0), 128'(4));
        check("back-to-back last addr", 128'(oCodeAddr), 128'(16'h0003));

        midWord = 1'b1;
        CYC_I = 1'b1; MST_I = 1'b1; WE_I = 4'(1 << CID); TAG_I = 2'd2; ADR_I = 32'h44;
        doBeat(32'hDEAD0001, 1'b0, ok, lat, ackAfter, busy, cwe, dwe);
        check("busy before reset", 128'(busy), 128'(1));
        #2 Reset = 1'b0;
        #1;
        check("mid-word reset ACK_O", 128'(ACK_O), 128'(0));
        check("mid-word reset oBusy", 128'(oBusy), 128'(0));
        check("mid-word reset oProtocolError", 128'(oProtocolError), 128'(0));
        check("mid-word reset oCodeAddr", 128'(oCodeAddr), 128'(0));
        check("mid-word reset oCodeData", 128'(oCodeData), 128'(0));
        check("mid-word reset oDataData", 128'(oDataData), 128'(0));
        CYC_I = 1'b0; STB_I = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b1;
        modelErr = 1'b0;
        midWord = 1'b0;
        @(posedge Clock); #1;
        doWord(2'd2, 32'h7, 32'h11111111, 32'h22222222, 32'h33333333, 0, 1'b0, 1, lat);
        check("data word after reset", 128'(oDataData), 128'(96'h111111112222222233333333));

        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 99);
            if (r < 15) begin
                otherCore($urandom_range(1, 3), r < 5);
            end else begin
                r = $urandom_range(0, 9);
                if (r == 0)     tag = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
                else if (r < 5) tag = 2'd1;
                else            tag = 2'd2;
                doWord(tag, $urandom, $urandom, $urandom, $urandom,
                       ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0,
                       1'($urandom_range(0, 1)), $urandom_range(0, 2), lat);
            end
        end

        repeat (3) @(posedge Clock);
        #1;
        check("code writes all seen", 128'(codeQ.size()), 128'(0));
        check("data writes all seen", 128'(dataQ.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
